// File: rtl/sprite_reg_bank.sv
// sprite_reg_bank: shadow/active sprite attribute store with a vblank-triggered commit.
// Ports:
//   clk, reset (async, active-low)
//   wr_en/wr_sel/wr_x/wr_y/wr_vis/wr_attr/wr_pos : shadow-bank write
//   clr_all : hide every sprite in the shadow bank
//   vblank  : display timing level; its rising edge starts a commit
//   rd_sel -> rd_x/rd_y/rd_vis/rd_attr/rd_pos : registered active-bank read
//   commit_busy, pending, frame_overrun : status
module sprite_reg_bank #(
    parameter int NUM_SPRITES = 32,
    parameter int X_W = 10,
    parameter int Y_W = 9,
    localparam int SEL_W = $clog2(NUM_SPRITES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic             wr_vis,
    input  logic             wr_attr,
    input  logic             wr_pos,
    input  logic             clr_all,
    input  logic             vblank,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_vis,
    output logic             rd_attr,
    output logic             rd_pos,
    output logic             commit_busy,
    output logic             pending,
    output logic             frame_overrun
);
    typedef enum logic {IDLE, COMMIT} state_t;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SPRITES - 1);

    logic [X_W-1:0] sh_x [NUM_SPRITES];
    logic [Y_W-1:0] sh_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_vis, sh_attr, sh_pos;
    logic [X_W-1:0] act_x [NUM_SPRITES];
    logic [Y_W-1:0] act_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] act_vis, act_attr, act_pos;
    logic [NUM_SPRITES-1:0] dirty;
    state_t state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic vb_q, vb_rise, wr_ok, rd_ok, copy;

    assign vb_rise = vblank & ~vb_q;
    assign wr_ok = wr_en && (int'(wr_sel) < NUM_SPRITES);
    assign rd_ok = int'(rd_sel) < NUM_SPRITES;
    assign copy = (state_q == COMMIT) && dirty[idx_q];
    assign pending = |dirty;
    assign commit_busy = state_q == COMMIT;

    always_comb begin
        state_d = (state_q == IDLE) ? (vb_rise ? COMMIT : IDLE) : (idx_q == LAST ? IDLE : COMMIT);
        idx_d = (state_q == COMMIT && idx_q != LAST) ? idx_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            vb_q <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            vb_q <= vblank;
            frame_overrun <= vb_rise && (state_q == COMMIT);
        end
    end

    // clr_all is applied first so a same-cycle write wins for its own entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
            sh_vis <= '0;
            sh_attr <= '0;
            sh_pos <= '0;
        end else begin
            if (clr_all) sh_vis <= '0;
            if (wr_ok) begin
                sh_x[wr_sel] <= wr_x;
                sh_y[wr_sel] <= wr_y;
                sh_vis[wr_sel] <= wr_vis;
                sh_attr[wr_sel] <= wr_attr;
                sh_pos[wr_sel] <= wr_pos;
            end
        end
    end

    // A write landing on the entry being copied keeps its dirty bit, so the
    // pre-write value is committed now and the new one next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty <= '0;
        end else begin
            if (copy) dirty[idx_q] <= 1'b0;
            if (clr_all) dirty <= '1;
            if (wr_ok) dirty[wr_sel] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act_x[i] <= '0;
                act_y[i] <= '0;
            end
            act_vis <= '0;
            act_attr <= '0;
            act_pos <= '0;
        end else if (copy) begin
            act_x[idx_q] <= sh_x[idx_q];
            act_y[idx_q] <= sh_y[idx_q];
            act_vis[idx_q] <= sh_vis[idx_q];
            act_attr[idx_q] <= sh_attr[idx_q];
            act_pos[idx_q] <= sh_pos[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_x <= '0;
            rd_y <= '0;
            rd_vis <= 1'b0;
            rd_attr <= 1'b0;
            rd_pos <= 1'b0;
        end else begin
            rd_x <= rd_ok ? act_x[rd_sel] : '0;
            rd_y <= rd_ok ? act_y[rd_sel] : '0;
            rd_vis <= rd_ok && act_vis[rd_sel];
            rd_attr <= rd_ok && act_attr[rd_sel];
            rd_pos <= rd_ok && act_pos[rd_sel];
        end
    end
endmodule

// File: tb/tb_sprite_reg_bank.sv
// tb_sprite_reg_bank: directed and random checks of sprite_reg_bank against a behavioural model.
module tb_sprite_reg_bank;
    localparam int N = 32;
    localparam int SW = 5;
    localparam int N2 = 24;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic wr_en = 0, wr_vis = 0, wr_attr = 0, wr_pos = 0, clr_all = 0, vblank = 0;
    logic [SW-1:0] wr_sel = '0, rd_sel = '0;
    logic [9:0] wr_x = '0, rd_x;
    logic [8:0] wr_y = '0, rd_y;
    logic rd_vis, rd_attr, rd_pos, commit_busy, pending, frame_overrun;

    logic b_wr_en = 0, b_clr = 0, b_vb = 0;
    logic [4:0] b_wr_sel = '0, b_rd_sel = '0;
    logic [9:0] b_rd_x;
    logic [8:0] b_rd_y;
    logic b_rd_vis, b_rd_attr, b_rd_pos, b_busy, b_pending, b_ovr;

    sprite_reg_bank #(.NUM_SPRITES(N)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
        .wr_vis(wr_vis), .wr_attr(wr_attr), .wr_pos(wr_pos), .clr_all(clr_all), .vblank(vblank),
        .rd_sel(rd_sel), .rd_x(rd_x), .rd_y(rd_y), .rd_vis(rd_vis), .rd_attr(rd_attr),
        .rd_pos(rd_pos), .commit_busy(commit_busy), .pending(pending), .frame_overrun(frame_overrun)
    );

    sprite_reg_bank #(.NUM_SPRITES(N2)) dut24 (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_x(wr_x), .wr_y(wr_y),
        .wr_vis(wr_vis), .wr_attr(wr_attr), .wr_pos(wr_pos), .clr_all(b_clr), .vblank(b_vb),
        .rd_sel(b_rd_sel), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_vis(b_rd_vis), .rd_attr(b_rd_attr),
        .rd_pos(b_rd_pos), .commit_busy(b_busy), .pending(b_pending), .frame_overrun(b_ovr)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic vis, attr, pos;
    } spr_t;

    spr_t m_sh [N];
    spr_t m_act [N];
    bit m_dirty [N];
    bit m_busy, m_vbq, m_ovr;
    int m_cur;
    spr_t m_rd;

    function automatic bit m_pend();
        for (int i = 0; i < N; i++) if (m_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
            m_dirty[i] = 0;
        end
        m_busy = 0; m_vbq = 0; m_ovr = 0; m_cur = 0; m_rd = '0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        spr_t w;
        bit rise;
        @(posedge clk);
        w = {wr_x, wr_y, wr_vis, wr_attr, wr_pos};
        rise = vblank && !m_vbq;
        m_rd = (int'(rd_sel) < N) ? m_act[rd_sel] : '0;
        m_ovr = rise && m_busy;
        if (m_busy && m_dirty[m_cur]) begin
            m_act[m_cur] = m_sh[m_cur];
            m_dirty[m_cur] = 0;
        end
        if (clr_all) for (int i = 0; i < N; i++) begin
            m_sh[i].vis = 0;
            m_dirty[i] = 1;
        end
        if (wr_en) begin
            m_sh[wr_sel] = w;
            m_dirty[wr_sel] = 1;
        end
        if (m_busy) begin
            if (m_cur == N - 1) m_busy = 0; else m_cur++;
        end else if (rise) begin
            m_busy = 1;
            m_cur = 0;
        end
        m_vbq = vblank;
        #1;
        check("rd", {rd_x, rd_y, rd_vis, rd_attr, rd_pos}, m_rd);
        check("busy", commit_busy, m_busy);
        check("pending", pending, m_pend());
        check("overrun", frame_overrun, m_ovr);
        @(negedge clk);
    endtask

    task automatic write(input int sel, input int x, input int y, input bit v);
        wr_en = 1; wr_sel = SW'(sel); wr_x = 10'(x); wr_y = 9'(y); wr_vis = v; wr_attr = 0; wr_pos = 0;
        step();
        wr_en = 0;
    endtask

    task automatic rise();
        vblank = 1;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && commit_busy; i++) step();
        check("drain_timeout", commit_busy, 0);
        vblank = 0;
        step();
    endtask

    task automatic commit();
        int n = 0;
        rise();
        while (commit_busy && n < 40) begin
            n++;
            step();
        end
        check("commit_len", n, N);
        vblank = 0;
        step();
    endtask

    task automatic read(input int sel);
        rd_sel = SW'(sel);
        step();
    endtask

    task automatic b_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, ov;
        m_reset();
        #12;
        check("rst_rd", {rd_x, rd_y, rd_vis, rd_attr, rd_pos}, 0);
        check("rst_busy", commit_busy, 0);
        check("rst_pend", pending, 0);
        check("rst_ovr", frame_overrun, 0);
        check("rst_b_pend", b_pending, 0);
        @(negedge clk);
        reset = 1;

        // T1: shadow write is not visible until a commit
        rd_sel = 3;
        write(3, 100, 50, 1);
        step();
        check("t1_rdx_pre", rd_x, 0);
        check("t1_pend", pending, 1);
        commit();
        read(3);
        check("t1_x", rd_x, 100);
        check("t1_y", rd_y, 50);
        check("t1_vis", rd_vis, 1);
        check("t1_pend_after", pending, 0);

        // T2: writes behind and ahead of the commit index
        rise();
        repeat (10) step();
        wr_en = 1; wr_sel = 5; wr_x = 7; wr_y = 0; wr_vis = 1;
        step();
        wr_sel = 20; wr_x = 9;
        step();
        wr_en = 0;
        drain();
        read(20);
        check("t2_x20", rd_x, 9);
        read(5);
        check("t2_x5_old", rd_x, 0);
        check("t2_pend", pending, 1);
        commit();
        read(5);
        check("t2_x5_new", rd_x, 7);

        // T3: write collides with the entry being copied
        write(7, 300, 1, 1);
        rise();
        repeat (7) step();
        write(7, 555, 2, 1);
        drain();
        read(7);
        check("t3_old", rd_x, 300);
        check("t3_pend", pending, 1);
        commit();
        read(7);
        check("t3_new", rd_x, 555);

        // T4: second vblank edge during a commit
        write(1, 11, 11, 1);
        rise();
        n = 1; ov = 0;
        for (int i = 0; i < 40 && commit_busy; i++) begin
            vblank = (i >= 4);
            step();
            n += int'(commit_busy);
            ov += int'(frame_overrun);
        end
        check("t4_len", n, N);
        check("t4_overruns", ov, 1);
        vblank = 0;
        step();

        // T5: clr_all hides everything
        for (int i = 0; i < N; i++) write(i, i, i, 1);
        commit();
        read(9);
        check("t5_vis_pre", rd_vis, 1);
        clr_all = 1;
        step();
        clr_all = 0;
        check("t5_pend", pending, 1);
        commit();
        for (int i = 0; i < N; i++) begin
            read(i);
            check("t5_vis", rd_vis, 0);
        end

        // Random traffic, including overruns and clr_all/write collisions
        repeat (3000) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_sel = SW'($urandom);
            wr_x = 10'($urandom);
            wr_y = 9'($urandom);
            wr_vis = 1'($urandom);
            wr_attr = 1'($urandom);
            wr_pos = 1'($urandom);
            clr_all = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) vblank = ~vblank;
            rd_sel = SW'($urandom);
            step();
        end
        wr_en = 0; clr_all = 0; vblank = 0;
        step();
        step();

        // T6: asynchronous reset in the middle of a commit
        write(25, 40, 40, 1);
        rise();
        repeat (11) step();
        write(28, 41, 41, 1);
        rd_sel = 25;
        #2 reset = 0;
        #1;
        check("t6_busy", commit_busy, 0);
        check("t6_pend", pending, 0);
        check("t6_rd", {rd_x, rd_y, rd_vis, rd_attr, rd_pos}, 0);
        m_reset();
        vblank = 0;
        @(negedge clk);
        reset = 1;
        read(25);
        check("t6_rd_after", rd_x, 0);

        // Non-power-of-two bank: out-of-range write and read, last valid index
        b_wr_en = 1; b_wr_sel = 30; wr_x = 77; wr_y = 3; wr_vis = 1;
        b_step();
        b_wr_en = 0;
        b_step();
        check("n24_oor_pend", b_pending, 0);
        b_vb = 1;
        b_step();
        n = 0;
        while (b_busy && n < 40) begin
            n++;
            b_step();
        end
        check("n24_len", n, N2);
        b_vb = 0;
        b_rd_sel = 30;
        b_step();
        b_step();
        check("n24_oor_rd", {b_rd_x, b_rd_y, b_rd_vis, b_rd_attr, b_rd_pos}, 0);
        b_wr_en = 1; b_wr_sel = 23;
        b_step();
        b_wr_en = 0;
        b_step();
        check("n24_last_pend", b_pending, 1);
        b_vb = 1;
        b_step();
        for (int i = 0; i < 40 && b_busy; i++) b_step();
        b_rd_sel = 23;
        b_step();
        b_step();
        check("n24_last_x", b_rd_x, 77);
        check("n24_last_pend0", b_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
